// File: rtl/dmem_access_sched_if.sv
// dmem_access_sched_if
//   Bundles the three buses of the data-memory access scheduler:
//     core_*  : scalar/vector load/store transaction port (level request,
//               one-cycle done pulse, error flag, 192-bit read data)
//     dump_*  : image-dump start switch and valid/ready word stream
//     mem_*   : 32-bit single-port RAM with 1-cycle synchronous read
//   Modports:
//     slave  : scheduler side
//     master : environment side (core, dump consumer and RAM)
interface dmem_access_sched_if #(
   parameter int S = 32,
   parameter int V = 192
);
   logic         core_req;
   logic         core_we;
   logic         core_vec;
   logic [S-1:0] core_addr;
   logic [V-1:0] core_wd;
   logic [V-1:0] core_rd;
   logic         core_done;
   logic         core_err;

   logic         dump_start;
   logic [S-1:0] dump_data;
   logic         dump_valid;
   logic         dump_ready;
   logic         dump_last;
   logic         dump_busy;

   logic         mem_en;
   logic         mem_we;
   logic [S-1:0] mem_addr;
   logic [S-1:0] mem_wd;
   logic [S-1:0] mem_rd;

   modport slave (
      input  core_req, core_we, core_vec, core_addr, core_wd,
      input  dump_start, dump_ready, mem_rd,
      output core_rd, core_done, core_err,
      output dump_data, dump_valid, dump_last, dump_busy,
      output mem_en, mem_we, mem_addr, mem_wd
   );

   modport master (
      output core_req, core_we, core_vec, core_addr, core_wd,
      output dump_start, dump_ready, mem_rd,
      input  core_rd, core_done, core_err,
      input  dump_data, dump_valid, dump_last, dump_busy,
      input  mem_en, mem_we, mem_addr, mem_wd
   );
endinterface

// File: rtl/dmem_access_sched.sv
// dmem_access_sched
//   Single-word access scheduler in front of the data-memory RAM. Core scalar
//   and vector (LANES-word) transactions are serialised into per-word RAM
//   beats; an image-dump streamer shares the RAM and reads words
//   0..DUMP_WORDS-1 after a rising edge of the dump_start switch. Core and
//   dump are arbitrated round-robin; a vector transaction is never split.
//   Ports:
//     clk    : clock, all state on the rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : dmem_access_sched_if.slave (core_*, dump_*, mem_* signals)
module dmem_access_sched #(
   parameter int S          = 32,
   parameter int V          = 192,
   parameter int DEPTH      = 30015,
   parameter int DUMP_WORDS = 30000
) (
   input logic              clk,
   input logic              rst_n,
   dmem_access_sched_if.slave bus
);
   localparam int LANES = V / S;
   localparam int BW    = $clog2(LANES);

   typedef enum logic [2:0] {
      IDLE, CORE_BEAT, CORE_FIN, CORE_RESP, DUMP_RD, DUMP_CAP
   } state_t;

   state_t state, state_n;

   // latched core transaction
   logic [S-1:0]            base;
   logic                    we_q;
   logic                    vec_q;
   logic [LANES-1:0][S-1:0] wd_q;
   logic [LANES-1:0][S-1:0] rd_q;
   logic [BW-1:0]           beat;
   logic                    err_q;

   // read data returns one cycle after its beat, so remember which lane
   logic                    cap_pend;
   logic [BW-1:0]           cap_lane;

   logic                    last_core;   // 1: core held the last grant

   // dump side
   logic [2:0]              sync;        // two sync flops + previous value
   logic                    start_edge;
   logic                    dump_busy;
   logic [S-1:0]            dump_addr;
   logic [S-1:0]            dump_data;
   logic                    dump_valid;
   logic                    dump_last;

   // combinational
   logic [S:0]              beat_addr;
   logic                    in_range;
   logic [BW-1:0]           last_beat;
   logic                    core_el;
   logic                    dump_el;
   logic                    grant_core;
   logic                    mem_en, mem_we;
   logic [S-1:0]            mem_addr, mem_wd;
   logic                    core_done, core_err;

   // one extra bit so an address past 2^S-1 is out of range, not wrapped
   assign beat_addr  = {1'b0, base} + {{(S + 1 - BW){1'b0}}, beat};
   assign in_range   = beat_addr < (S + 1)'(DEPTH);
   assign last_beat  = vec_q ? BW'(LANES - 1) : '0;
   assign start_edge = sync[1] & ~sync[2];

   assign core_el = bus.core_req;
   assign dump_el = dump_busy & ~dump_valid & (dump_addr < S'(DUMP_WORDS));

   always_comb begin
      state_n    = state;
      grant_core = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wd     = '0;
      core_done  = 1'b0;
      core_err   = 1'b0;
      case (state)
         IDLE: begin
            // on a tie the side that did not win last time goes first
            if (core_el && (!dump_el || !last_core)) begin
               grant_core = 1'b1;
               state_n    = CORE_BEAT;
            end else if (dump_el) begin
               state_n = DUMP_RD;
            end
         end
         CORE_BEAT: begin
            mem_en   = in_range;
            mem_we   = we_q;
            mem_addr = beat_addr[S-1:0];
            mem_wd   = wd_q[beat];
            if (beat == last_beat) state_n = CORE_FIN;
         end
         CORE_FIN:  state_n = CORE_RESP;
         CORE_RESP: begin
            core_done = 1'b1;
            core_err  = err_q;
            state_n   = IDLE;
         end
         DUMP_RD: begin
            mem_en   = 1'b1;
            mem_addr = dump_addr;
            state_n  = DUMP_CAP;
         end
         DUMP_CAP:  state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         base      <= '0;
         we_q      <= 1'b0;
         vec_q     <= 1'b0;
         wd_q      <= '0;
         rd_q      <= '0;
         beat      <= '0;
         err_q     <= 1'b0;
         cap_pend  <= 1'b0;
         cap_lane  <= '0;
         last_core <= 1'b0;
      end else begin
         state    <= state_n;
         cap_pend <= (state == CORE_BEAT) && in_range && !we_q;
         cap_lane <= beat;
         if (cap_pend) rd_q[cap_lane] <= bus.mem_rd;
         if (grant_core) begin
            base  <= bus.core_addr;
            we_q  <= bus.core_we;
            vec_q <= bus.core_vec;
            wd_q  <= bus.core_wd;
            beat  <= '0;
            err_q <= 1'b0;
            rd_q  <= '0;
         end else if (state == CORE_BEAT) begin
            if (!in_range) err_q <= 1'b1;
            if (beat != last_beat) beat <= beat + 1'b1;
         end
         if (state == CORE_RESP)     last_core <= 1'b1;
         else if (state == DUMP_CAP) last_core <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync       <= '0;
         dump_busy  <= 1'b0;
         dump_addr  <= '0;
         dump_data  <= '0;
         dump_valid <= 1'b0;
         dump_last  <= 1'b0;
      end else begin
         sync <= {sync[1:0], bus.dump_start};
         // a start edge during a running dump is ignored
         if (start_edge && !dump_busy) begin
            dump_busy <= 1'b1;
            dump_addr <= '0;
         end else if (dump_valid && bus.dump_ready && dump_last) begin
            dump_busy <= 1'b0;
            dump_addr <= '0;
         end else if (state == DUMP_CAP) begin
            dump_addr <= dump_addr + 1'b1;
         end
         if (state == DUMP_CAP) begin
            dump_data  <= bus.mem_rd;
            dump_valid <= 1'b1;
            dump_last  <= (dump_addr == S'(DUMP_WORDS - 1));
         end else if (dump_valid && bus.dump_ready) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
         end
      end
   end

   assign bus.core_rd    = rd_q;
   assign bus.core_done  = core_done;
   assign bus.core_err   = core_err;
   assign bus.dump_data  = dump_data;
   assign bus.dump_valid = dump_valid;
   assign bus.dump_last  = dump_last;
   assign bus.dump_busy  = dump_busy;
   assign bus.mem_en     = mem_en;
   assign bus.mem_we     = mem_we;
   assign bus.mem_addr   = mem_addr;
   assign bus.mem_wd     = mem_wd;
endmodule

// File: tb/tb_dmem_access_sched.sv
// Testbench for dmem_access_sched: a RAM model answers the mem_* bus, a
// reference memory predicts each core response when the transaction is
// issued, and one monitor checks core responses, dump words and stalls.
module tb_dmem_access_sched;
   localparam int S = 32, V = 192, LANES = 6, DEPTH = 256, DW = 8;

   typedef struct {
      logic [V-1:0] rd;
      logic         err;
      int           lat;
      int           issue;
   } exp_t;

   typedef struct {
      logic         we;
      logic [S-1:0] addr;
      int           c;
   } tr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   dmem_access_sched_if #(.S(S), .V(V)) bus ();

   dmem_access_sched #(.S(S), .V(V), .DEPTH(DEPTH), .DUMP_WORDS(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int           n_chk = 0;
   int           n_fail = 0;
   int           cyc = 0;
   logic [S-1:0] ram     [DEPTH];
   logic [S-1:0] ref_mem [DEPTH];
   exp_t         sbq[$];
   tr_t          trq[$];

   // monitor state
   exp_t         e_mon;
   tr_t          t_mon;
   int           dexp = 0;
   int           dwords = 0;
   int           dw_prev = 0;
   bit           prev_busy = 0;
   bit           chk_alt = 0;
   bit           stall_v = 0;
   bit           last_acc = 0;
   logic [S-1:0] stall_d;

   task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: 1-cycle synchronous read
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wd;
         else            bus.mem_rd <= ram[bus.mem_addr[7:0]];
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         dexp     = 0;
         stall_v  = 0;
         last_acc = 0;
      end else begin
         if (bus.mem_en) begin
            chk("mem_addr_range", bus.mem_addr < DEPTH, 1);
            t_mon.we = bus.mem_we; t_mon.addr = bus.mem_addr; t_mon.c = cyc;
            trq.push_back(t_mon);
         end
         if (last_acc) chk("dump_busy_fall", bus.dump_busy, 0);
         if (stall_v) begin
            chk("dump_hold_valid", bus.dump_valid, 1);
            chk("dump_hold_data", bus.dump_data, stall_d);
         end
         stall_v  = bus.dump_valid && !bus.dump_ready;
         stall_d  = bus.dump_data;
         last_acc = bus.dump_valid && bus.dump_ready && bus.dump_last;
         if (bus.dump_valid && bus.dump_ready) begin
            chk("dump_data", bus.dump_data, ref_mem[dexp]);
            chk("dump_last", bus.dump_last, dexp == DW - 1);
            dwords++;
            dexp = (dexp == DW - 1) ? 0 : dexp + 1;
         end
         if (bus.core_done) begin
            chk("sb_nonempty", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
               e_mon = sbq.pop_front();
               chk("core_rd", bus.core_rd, e_mon.rd);
               chk("core_err", bus.core_err, e_mon.err);
               if (e_mon.lat >= 0) chk("core_latency", cyc - e_mon.issue, e_mon.lat);
            end
            if (chk_alt && bus.dump_busy && prev_busy)
               chk("alternation", dwords - dw_prev, 1);
            prev_busy = bus.dump_busy;
            dw_prev   = dwords;
         end
      end
   end

   function automatic logic [V-1:0] rand_vec();
      logic [V-1:0] d;
      for (int k = 0; k < LANES; k++) d[k*S +: S] = $urandom;
      return d;
   endfunction

   // Issue one transaction in the next cycle; expectation comes from the
   // reference memory with plain per-word address arithmetic.
   task automatic core_txn(input bit we, input bit vec, input logic [S-1:0] addr,
                           input logic [V-1:0] wd, input bit hold, input bit lat_chk);
      exp_t       e;
      logic [S:0] a;
      int         n;
      bit         ok;
      @(negedge clk);
      bus.core_we   = we;
      bus.core_vec  = vec;
      bus.core_addr = addr;
      bus.core_wd   = wd;
      bus.core_req  = 1'b1;
      n     = vec ? LANES : 1;
      e.rd  = '0;
      e.err = 1'b0;
      for (int k = 0; k < n; k++) begin
         a = {1'b0, addr} + (S + 1)'(k);
         if (a < (S + 1)'(DEPTH)) begin
            if (we) ref_mem[a[7:0]] = wd[k*S +: S];
            else    e.rd[k*S +: S] = ref_mem[a[7:0]];
         end else begin
            e.err = 1'b1;
         end
      end
      e.lat   = lat_chk ? n + 2 : -1;
      e.issue = cyc;
      sbq.push_back(e);
      ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = bus.core_done;
      end
      chk("core_done_timeout", ok, 1);
      if (!hold) bus.core_req = 1'b0;
   endtask

   task automatic chk_trace(input string name, input int n, input logic we, input logic [S-1:0] base);
      chk({name, "_beats"}, trq.size(), n);
      for (int k = 0; k < trq.size() && k < n; k++) begin
         chk({name, "_addr"}, trq[k].addr, base + S'(k));
         chk({name, "_we"}, trq[k].we, we);
         if (k > 0) chk({name, "_gap"}, trq[k].c - trq[k-1].c, 1);
      end
   endtask

   task automatic wait_sig(input string name, input bit busy_not_valid, input logic val);
      bit ok;
      ok = 0;
      for (int t = 0; t < 400 && !ok; t++) begin
         @(negedge clk);
         ok = busy_not_valid ? (bus.dump_busy == val) : (bus.dump_valid == val);
      end
      chk(name, ok, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [S-1:0] a;
      logic [V-1:0] d;
      int           sel, d0;

      for (int i = 0; i < DEPTH; i++) begin
         d = rand_vec();
         ram[i]     <= d[S-1:0];
         ref_mem[i] = d[S-1:0];
      end
      bus.core_req = 0; bus.core_we = 0; bus.core_vec = 0;
      bus.core_addr = '0; bus.core_wd = '0;
      bus.dump_start = 0; bus.dump_ready = 0; bus.mem_rd = '0;

      // reset state
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_core_rd", bus.core_rd, '0);
      chk("rst_ctl", {bus.core_done, bus.core_err, bus.dump_data, bus.dump_valid,
                      bus.dump_last, bus.dump_busy, bus.mem_en, bus.mem_we,
                      bus.mem_addr, bus.mem_wd}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // scalar store / load
      trq.delete();
      core_txn(1, 0, 100, {160'd0, 32'hDEAD_BEEF}, 0, 1);
      chk_trace("st_scalar", 1, 1, 100);
      core_txn(0, 0, 100, rand_vec(), 0, 1);

      // vector store / load
      trq.delete();
      core_txn(1, 1, 200, {32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11}, 0, 1);
      chk_trace("st_vector", 6, 1, 200);
      core_txn(0, 1, 200, '0, 0, 1);

      // partly and fully out-of-range vector loads
      trq.delete();
      core_txn(0, 1, DEPTH - 3, '0, 0, 1);
      chk_trace("ld_edge", 3, 0, DEPTH - 3);
      trq.delete();
      core_txn(0, 1, 32'hFFFF_FFFD, '0, 0, 1);
      chk("ld_wrap_beats", trq.size(), 0);

      // random mix, dense addresses for store/load reuse plus boundaries
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6)      a = $urandom_range(0, 24);
         else if (sel < 9) a = DEPTH - 8 + $urandom_range(0, 10);
         else              a = 32'hFFFF_FFFF - $urandom_range(0, 6);
         core_txn($urandom_range(0, 1), $urandom_range(0, 1), a, rand_vec(),
                  $urandom_range(0, 1), 1);
      end
      bus.core_req = 0;

      // dump alone, second start mid-dump must be ignored
      bus.dump_ready = 1;
      d0 = dwords;
      @(negedge clk);
      bus.dump_start = 1;
      wait_sig("dump_busy_rise", 1, 1);
      repeat (4) @(negedge clk);
      bus.dump_start = 0;
      repeat (4) @(negedge clk);
      bus.dump_start = 1;
      wait_sig("dump_done", 1, 0);
      repeat (4) @(negedge clk);
      chk("dump_words", dwords - d0, DW);
      chk("dump_idle_valid", bus.dump_valid, 0);

      // contention: core request held, grants alternate with dump words
      bus.dump_start = 0;
      repeat (4) @(negedge clk);
      d0 = dwords;
      chk_alt = 1;
      bus.dump_start = 1;
      for (int i = 0; i < 5; i++)
         core_txn($urandom_range(0, 1), $urandom_range(0, 1),
                  DW + $urandom_range(0, 200), rand_vec(), i < 4, 0);
      chk_alt = 0;
      bus.dump_ready = 0;
      wait_sig("stall_valid", 0, 1);
      // buffer full: the core runs back-to-back at full latency
      for (int i = 0; i < 5; i++)
         core_txn($urandom_range(0, 1), 0, DW + $urandom_range(0, 200), rand_vec(), i < 4, 1);
      chk("stall_busy", bus.dump_busy, 1);
      chk("stall_valid_held", bus.dump_valid, 1);
      bus.dump_ready = 1;
      wait_sig("dump_done2", 1, 0);
      repeat (2) @(negedge clk);
      chk("dump_words2", dwords - d0, DW);

      // reset during vector beat 3 with a dump pending
      bus.dump_start = 0;
      bus.dump_ready = 0;
      repeat (4) @(negedge clk);
      bus.dump_start = 1;
      wait_sig("rst_dump_valid", 0, 1);
      @(negedge clk);
      bus.core_we = 0; bus.core_vec = 1; bus.core_addr = 40; bus.core_req = 1;
      repeat (4) @(posedge clk);
      #1;
      chk("beat3_en", bus.mem_en, 1);
      chk("beat3_addr", bus.mem_addr, 43);
      rst_n = 1'b0;
      bus.core_req = 0;
      bus.dump_start = 0;
      #1;
      chk("rst2_core_rd", bus.core_rd, '0);
      chk("rst2_ctl", {bus.core_done, bus.core_err, bus.dump_data, bus.dump_valid,
                       bus.dump_last, bus.dump_busy, bus.mem_en, bus.mem_we,
                       bus.mem_addr, bus.mem_wd}, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_busy", bus.dump_busy, 0);
      bus.dump_ready = 1;
      core_txn(0, 0, 100, '0, 0, 1);
      repeat (3) @(negedge clk);
      chk("sb_drained", sbq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_access_sched.md
Name: dmem_access_sched

Overview:
- Single-word access scheduler in front of the data-memory RAM. The RAM is a 32-bit, single-port array with 1-cycle synchronous read.
- Serialises core scalar and vector (6-lane, 192-bit) load/store transactions into per-word RAM beats.
- Shares the RAM with an image-dump streamer that reads the frame region word by word after the start switch.
- Round-robin arbitration between core and dump; vector transactions are atomic.

Parameters:
S, 32, word width
V, 192, vector width; LANES = V/S = 6
DEPTH, 30015, RAM words; valid addresses 0..DEPTH-1
DUMP_WORDS, 30000, words streamed per dump, addresses 0..DUMP_WORDS-1

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
core_req  in  1  core transaction request, level
core_we  in  1  1=store, 0=load
core_vec  in  1  1=vector (LANES words), 0=scalar (1 word)
core_addr  in  S  base word address
core_wd  in  V  store data; lane k = bits [k*S+S-1:k*S]
core_rd  out  V  load data, stable from core_done until next acceptance
core_done  out  1  one-cycle completion pulse
core_err  out  1  valid with core_done; some beat was out of range
dump_start  in  1  asynchronous switch; rising edge starts a dump
dump_data  out  S  streamed word
dump_valid  out  1  dump_data valid
dump_ready  in  1  consumer accepts when valid&ready
dump_last  out  1  with dump_valid, marks word DUMP_WORDS-1
dump_busy  out  1  dump in progress
mem_en  out  1  RAM access this cycle
mem_we  out  1  RAM write
mem_addr  out  S  RAM word address
mem_wd  out  S  RAM write data
mem_rd  in  S  RAM read data, valid the cycle after a read beat

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all outputs 0; core_rd=0.
  - Dump cancelled, dump address=0, output buffer empty.
  - last_grant=DUMP, so the core wins the first tie.
  - A transaction in flight when reset asserts is discarded; the core must re-request.
- dump_start handling: 2-flop synchroniser plus rising-edge detect.
  - An edge while dump_busy=0 sets dump_busy=1 and dump address=0.
  - An edge while dump_busy=1 is ignored.
- FSM states: IDLE, CORE_BEAT, CORE_FIN, CORE_RESP, DUMP_RD, DUMP_CAP.
- IDLE:
  - Core eligible = core_req. Dump eligible = dump_busy & output buffer empty & words remain.
  - Both eligible: grant the requester other than last_grant. One eligible: grant it. None: stay.
  - Core grant latches addr, we, vec and wd; beat counter=0; nbeats = vec ? LANES : 1; core_rd cleared to 0; next state CORE_BEAT.
  - Dump grant: next state DUMP_RD.
- CORE_BEAT, beat k:
  - mem_en=1 when base+k < DEPTH, else 0 and err flag set.
  - mem_we=we; mem_addr=base+k; mem_wd=lane k.
  - k=nbeats-1 goes to CORE_FIN, else k+1.
  - Beats are issued on consecutive cycles with no gaps.
- Read capture: on the edge after each read beat, mem_rd is written into core_rd lane k. Suppressed (out-of-range) beats leave the lane 0. Scalar loads leave lanes 1..5 at 0.
- CORE_FIN: no RAM access; the last lane is captured here. Next state CORE_RESP.
- CORE_RESP: core_done=1 and core_err=err for exactly this cycle; next state IDLE; last_grant=CORE.
- Core latency: core_done is high in cycle nbeats+2 after the acceptance edge (scalar 3, vector 8), for both loads and stores.
- Dropping core_req mid-transaction does not abort; core_done still pulses.
- A new transaction may be accepted in the IDLE cycle right after CORE_RESP.
- DUMP_RD: mem_en=1, mem_we=0, mem_addr=dump address. Next state DUMP_CAP.
- DUMP_CAP: dump_data<=mem_rd; dump_valid<=1; dump_last<=(addr==DUMP_WORDS-1); dump address+1; last_grant=DUMP; next state IDLE.
- Dump output handshake:
  - dump_data, dump_valid and dump_last hold until valid&ready.
  - No new dump read is issued while the buffer is full; the core may still be served.
  - When the last word is accepted: dump_busy=0 and dump address=0.
- Dump words are strictly in ascending address order with no skips or duplicates.
- mem_en=0 in IDLE, CORE_FIN, CORE_RESP and DUMP_CAP. At most one RAM access per cycle.
- Addresses are unsigned. base+k is computed at S+1 bits, so no wrap: an overflowing address counts as out of range.

Test Plan:
- Scalar store then load at addr 100, wd lane0=0xDEADBEEF: store issues a single mem_we=1 beat at addr 100 and core_done at cycle 3. The load returns core_rd=0x...0000_DEADBEEF (upper lanes 0), core_done at cycle 3, core_err=0.
- Vector store at 200, lanes 0x11..0x66: mem_addr 200..205 on 6 consecutive cycles. A vector load then returns the same 192 bits, with core_done at cycle 8.
- Vector load at DEPTH-3: beats 3..5 have mem_en=0; lanes 3..5=0; core_err=1 with core_done.
- Dump with DUMP_WORDS=8 and dump_ready held 1: 8 words from addresses 0..7 in order, dump_last only on word 7, then dump_busy falls. A second dump_start mid-dump is ignored.
- Contention: core_req held high continuously while a dump runs. Grants alternate: core transaction, dump word, core transaction, and so on. dump_ready=0 for 20 cycles stalls the dump with dump_data held, while core transactions continue back-to-back.
- rst_n pulsed low during vector beat 3: all outputs 0 immediately, no core_done, dump_busy=0. After release, a fresh scalar load completes normally.
